// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants, state encoding and helper function shared by the UART transmit
// side (uart_tx_arbiter) and the matching receiver. Both ends import this so
// the frame format cannot drift between them.
//   Frame: start(0), 8 data bits MSB first, even parity, stop(1).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit that makes the count of ones in data+parity even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin requester selection. The grant is combinational from the
// request vector and a registered pointer; the search starts at the pointer
// and wraps at NUM_REQ. When i_en is high the pointer moves to one past the
// winner, so a requester that keeps asking waits for everyone else.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointer -> 0)
//   i_req         request vector
//   i_en          advance the pointer past the current winner
//   o_grant       one-hot grant (all zero when nobody requests)
//   o_grant_idx   index of the winner
//   o_valid       at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [2:0]         o_grant_idx,
  output logic               o_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // (base + off) mod NUM_REQ without a divider; off never exceeds NUM_REQ.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // otherwise the paths that skip an assignment would infer latches.
    w_idx   = '0;
    w_found = 1'b0;
    o_grant = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!w_found && i_req[wrap_add(r_ptr, o)]) begin
        w_found = 1'b1;
        w_idx   = wrap_add(r_ptr, o);
      end
    end
    o_grant[w_idx] = w_found;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= wrap_add(w_idx, 1);
    end
  end

  assign o_grant_idx = 3'(w_idx);
  assign o_valid     = w_found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART line between NUM_REQ byte producers. In IDLE a round-robin
// arbiter picks one requester; its byte is latched, acknowledged with a
// one-clk ack pulse and sent as start, 8 data bits MSB first, even parity,
// stop. Each bit lasts CLKS_PER_BIT clks. req/data_in are ignored while a
// frame is in flight.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset, abandons any frame
//   req         per-requester request, held while its byte is valid
//   data_in     byte of requester i on bits [8i+7:8i]
//   ack         one-clk pulse: byte of requester i latched
//   grant_id    requester of the frame in flight / last sent
//   busy        high while a frame is on the line
//   serial_out  UART line, idles high
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 serial_out
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  uart_state_e               r_state, w_state_nxt;
  logic [TW-1:0]             r_timer, w_timer_nxt;
  logic [2:0]                r_bit_idx, w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      r_serial, w_serial_nxt;
  logic                      r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0]        r_ack, w_ack_nxt;
  logic [2:0]                r_grant_id, w_grant_id_nxt;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [2:0]         w_arb_idx;
  logic               w_arb_valid;
  logic               w_arb_en;
  logic               w_expire;
  logic [2:0]         w_bit_idx_dec;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req),
    .i_en        (w_arb_en),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx),
    .o_valid     (w_arb_valid)
  );

  assign w_expire      = (r_timer == '0);
  assign w_bit_idx_dec = r_bit_idx - 3'd1;

  always_comb begin
    w_state_nxt    = r_state;
    // Free-running countdown; it is reloaded on every state entry below and
    // parks at zero in IDLE.
    w_timer_nxt    = w_expire ? '0 : r_timer - 1'b1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_serial_nxt   = r_serial;
    w_busy_nxt     = r_busy;
    w_ack_nxt      = '0;
    w_grant_id_nxt = r_grant_id;
    w_arb_en       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_serial_nxt = 1'b1;
        if (w_arb_valid) begin
          w_arb_en       = 1'b1;
          w_shift_nxt    = data_in[{w_arb_idx, 3'b000} +: UART_DATA_BITS];
          w_grant_id_nxt = w_arb_idx;
          w_ack_nxt      = w_arb_grant;
          w_busy_nxt     = 1'b1;
          w_serial_nxt   = 1'b0;
          w_timer_nxt    = BIT_LAST;
          w_bit_idx_nxt  = 3'd7;
          w_state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (w_expire) begin
          w_serial_nxt  = r_shift[7];
          w_bit_idx_nxt = 3'd7;
          w_timer_nxt   = BIT_LAST;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_timer_nxt = BIT_LAST;
          if (r_bit_idx == 3'd0) begin
            w_serial_nxt = even_parity(r_shift);
            w_state_nxt  = ST_PARITY;
          end else begin
            w_bit_idx_nxt = w_bit_idx_dec;
            w_serial_nxt  = r_shift[w_bit_idx_dec];
          end
        end
      end
      ST_PARITY: begin
        if (w_expire) begin
          w_serial_nxt = 1'b1;
          w_timer_nxt  = BIT_LAST;
          w_state_nxt  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          w_serial_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= 3'd7;
      r_shift    <= '0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      r_grant_id <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_serial   <= w_serial_nxt;
      r_busy     <= w_busy_nxt;
      r_ack      <= w_ack_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  assign ack        = r_ack;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign serial_out = r_serial;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Two DUTs share clock and reset: dut_a with CLKS_PER_BIT=4, dut_b with
// CLKS_PER_BIT=1. A frame-level model (expected bit list + elapsed-clock
// count) predicts every output each cycle; directed sequences add literal
// expectations for frame bits, grant order and timing.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_a = '0, req_b = '0;
  logic [8*N-1:0] data_a = '0, data_b = '0;
  logic [N-1:0]   ack_a, ack_b;
  logic [2:0]     gid_a, gid_b;
  logic           busy_a, busy_b, ser_a, ser_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(data_a),
    .ack(ack_a), .grant_id(gid_a), .busy(busy_a), .serial_out(ser_a)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(data_b),
    .ack(ack_b), .grant_id(gid_b), .busy(busy_b), .serial_out(ser_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit           m_busy [2] = '{0, 0};
  int           m_cnt  [2] = '{0, 0};   // clks elapsed since the granting edge
  logic [10:0]  m_frame[2] = '{'1, '1}; // m_frame[b] = b-th bit on the line
  int           m_ptr  [2] = '{0, 0};
  int           m_gid  [2] = '{0, 0};
  logic [N-1:0] m_ack  [2] = '{'0, '0};

  function automatic int cpb_of(input int m);
    return (m == 0) ? CPB_A : CPB_B;
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[7-i];
    f[9]  = ^b;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic model_step(input int m, input logic [N-1:0] r, input logic [8*N-1:0] d);
    int g;
    g = -1;
    m_ack[m] = '0;
    if (m_busy[m]) begin
      m_cnt[m]++;
      if (m_cnt[m] == 11 * cpb_of(m)) m_busy[m] = 0;
    end else if (r != '0) begin
      for (int o = 0; o < N; o++)
        if (g < 0 && r[(m_ptr[m] + o) % N]) g = (m_ptr[m] + o) % N;
      m_frame[m] = build_frame(d[8*g +: 8]);
      m_gid[m]   = g;
      m_ack[m]   = N'(1) << g;
      m_ptr[m]   = (g + 1) % N;
      m_busy[m]  = 1;
      m_cnt[m]   = 0;
    end
  endtask

  function automatic logic exp_serial(input int m);
    if (!m_busy[m]) return 1'b1;
    return m_frame[m][m_cnt[m] / cpb_of(m)];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0; m_gid[m] = 0; m_ack[m] = '0;
      end
    end else begin
      model_step(0, req_a, data_a);
      model_step(1, req_b, data_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_serial",   32'(ser_a),  32'(exp_serial(0)));
      check("a_busy",     32'(busy_a), 32'(m_busy[0]));
      check("a_ack",      32'(ack_a),  32'(m_ack[0]));
      check("a_grant_id", 32'(gid_a),  m_gid[0]);
      check("b_serial",   32'(ser_b),  32'(exp_serial(1)));
      check("b_busy",     32'(busy_b), 32'(m_busy[1]));
      check("b_ack",      32'(ack_b),  32'(m_ack[1]));
      check("b_grant_id", 32'(gid_b),  m_gid[1]);
    end
  end

  // Capture one dut_a frame: bits[10] is the start bit, bits[0] the stop bit,
  // each sampled mid-bit. At clk 6 of the frame (inside DATA) req/data are
  // replaced by req_after/data_after.
  task automatic capture_a(input logic [N-1:0] req_after, input logic [8*N-1:0] data_after,
                           output logic [10:0] bits, output int len, output int gid,
                           output int acks);
    bit seen;
    int k;
    seen = 0; bits = '1; len = 0; gid = -1; acks = 0; k = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (busy_a) seen = 1;
    end
    check("a_frame_start_timeout", 32'(seen), 32'd1);
    while (seen && busy_a && k < 100) begin
      if (k == 0) gid = int'(gid_a);
      if (k % CPB_A == CPB_A / 2) bits[10 - k / CPB_A] = ser_a;
      for (int i = 0; i < N; i++) if (ack_a[i]) acks++;
      if (k == 6) begin
        req_a  = req_after;
        data_a = data_after;
      end
      k++;
      @(negedge clk);
    end
    len = k;
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  par_bytes[3];
    logic [10:0] par_frames[3];
    logic [7:0]  bytes4[4];
    int len, gid, acks, idle_bad, t, tw;
    int ack_times[$];

    // ---- reset, applied without a clock edge ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_serial_a", 32'(ser_a),  32'd1);
    check("rst_busy_a",   32'(busy_a), 32'd0);
    check("rst_ack_a",    32'(ack_a),  32'd0);
    check("rst_gid_a",    32'(gid_a),  32'd0);
    check("rst_serial_b", 32'(ser_b),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_serial", 32'(ser_a), 32'd1);
    check("idle_ack",    32'(ack_a), 32'd0);

    // ---- single frame 0xA5 ----
    data_a[7:0] = 8'hA5;
    req_a       = 4'b0001;
    capture_a(4'b0000, data_a, bits, len, gid, acks);
    check("a5_bits", 32'(bits), 32'(11'b01010010101));
    check("a5_len",  len, 44);
    check("a5_gid",  gid, 0);
    check("a5_acks", acks, 1);

    // ---- parity ----
    par_bytes  = '{8'h07, 8'h00, 8'hFF};
    par_frames = '{11'b00000011111, 11'b00000000001, 11'b01111111101};
    for (int i = 0; i < 3; i++) begin
      data_a[7:0] = par_bytes[i];
      req_a       = 4'b0001;
      capture_a(4'b0000, data_a, bits, len, gid, acks);
      check("parity_bit",   32'(bits[1]), 32'(par_frames[i][1]));
      check("parity_frame", 32'(bits),    32'(par_frames[i]));
    end

    // ---- reset in the middle of DATA ----
    data_a[7:0] = 8'hA5;
    req_a       = 4'b0001;
    tw = 0;
    while (!busy_a && tw < 50) begin @(negedge clk); tw++; end
    check("midrst_frame_started", 32'(busy_a), 32'd1);
    repeat (10) @(negedge clk);
    req_a = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_serial", 32'(ser_a),  32'd1);
    check("midrst_busy",   32'(busy_a), 32'd0);
    check("midrst_gid",    32'(gid_a),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_serial", 32'(ser_a), 32'd1);
    check("post_rst_ack",    32'(ack_a), 32'd0);

    // ---- all four requesting: order 0,1,2,3 ----
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    data_a = {8'h44, 8'h33, 8'h22, 8'h11};
    req_a  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      capture_a((i == 3) ? 4'b0101 : 4'b1111, data_a, bits, len, gid, acks);
      check("rr4_gid",  gid, i);
      check("rr4_byte", 32'(bits[9:2]), 32'(bytes4[i]));
      check("rr4_acks", acks, 1);
    end
    // The pointer sits at 0 after granting 3, so requester 0 wins first.
    for (int i = 0; i < 4; i++) begin
      capture_a((i == 3) ? 4'b0000 : 4'b0101, data_a, bits, len, gid, acks);
      check("rr2_gid",  gid, (i % 2 == 0) ? 0 : 2);
      check("rr2_byte", 32'(bits[9:2]), 32'(bytes4[(i % 2 == 0) ? 0 : 2]));
    end

    // ---- req/data changed mid-frame ----
    data_a[15:8] = 8'h5A;
    req_a        = 4'b0010;
    capture_a(4'b0000, {data_a[31:16], 8'hC3, data_a[7:0]}, bits, len, gid, acks);
    check("drop_bits", 32'(bits), 32'(11'b00101101001));
    check("drop_gid",  gid, 1);
    check("drop_acks", acks, 1);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a || ack_a != '0 || !ser_a) idle_bad++;
    end
    check("drop_stays_idle", idle_bad, 0);

    // ---- CLKS_PER_BIT=1 back-to-back ----
    data_b[7:0] = 8'hC3;
    req_b       = 4'b0001;
    t = 0;
    while (ack_times.size() < 4 && t < 200) begin
      @(negedge clk);
      t++;
      if (ack_b[0]) ack_times.push_back(t);
    end
    check("b_ack_count", ack_times.size(), 4);
    if (ack_times.size() == 4) begin
      check("b_first_ack", ack_times[0], 1);
      for (int i = 1; i < 4; i++) check("b_frame_period", ack_times[i] - ack_times[i-1], 12);
    end
    req_b = 4'b0000;
    repeat (15) @(negedge clk);
    check("b_idle_after", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
